// File: rtl/uart_imem_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader_if
// Brief    : Loader outputs: instruction memory write port plus core control.
// Revision : 1.0 - initial release
// ============================================================================
interface uart_imem_loader_if #(
   parameter int ADDR_W = 12
);
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic              core_hold;
   logic              busy;
   logic              done;
   logic              err;

   modport master (output im_we, im_addr, im_wdata, core_hold, busy, done, err);
   modport slave  (input  im_we, im_addr, im_wdata, core_hold, busy, done, err);
endinterface
`default_nettype wire

// File: rtl/uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : uart_imem_loader
// Brief    : Receives a program image over UART, writes it into instruction
//            memory and holds the core in reset until a load succeeds.
// Revision : 1.0 - initial release
// ============================================================================
module uart_imem_loader #(
   parameter int CLK_FREQ     = 27000000,
   parameter int BAUD         = 115200,
   parameter int ADDR_W       = 12,
   parameter int TIMEOUT_CLKS = 2700000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_i,
   uart_imem_loader_if.master bus
);
   localparam int              c_CLKS_PER_BIT = CLK_FREQ / BAUD;
   localparam int              c_HALF_BIT     = c_CLKS_PER_BIT / 2;
   localparam int              c_CNT_W        = $clog2(c_CLKS_PER_BIT + 1);
   localparam int              c_TMO_W        = $clog2(TIMEOUT_CLKS + 1);
   localparam logic [16:0]     c_N_MAX        = 17'(2 ** ADDR_W);
   localparam logic [7:0]      c_SYNC         = 8'hA5;

   typedef enum logic [1:0] {RX_IDLE, RX_START, RX_BITS, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {WAIT_SYNC, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERROR} state_t;

   logic               r_rx_meta, r_rx_sync, r_rx_prev;
   rx_state_t          r_rx_state, w_rx_state_nx;
   logic [c_CNT_W-1:0] r_rx_cnt, w_rx_cnt_nx;
   logic [2:0]         r_rx_bit, w_rx_bit_nx;
   logic [7:0]         r_rx_shift, w_rx_shift_nx;
   logic               w_cnt_full, w_byte_valid, w_frame_err;

   state_t             r_state, w_state_nx;
   logic [7:0]         r_len_lo, w_len_lo_nx;
   logic [ADDR_W:0]    r_n, w_n_nx, r_idx, w_idx_nx;
   logic [31:0]        r_word, w_word_nx;
   logic [1:0]         r_byte_cnt, w_byte_cnt_nx;
   logic [7:0]         r_csum, w_csum_nx;
   logic [c_TMO_W-1:0] r_tmo;
   logic               r_we, w_we_nx;
   logic [ADDR_W-1:0]  r_addr, w_addr_nx;
   logic [31:0]        r_wdata, w_wdata_nx;
   logic               w_busy, w_timeout;
   logic [16:0]        w_n_rx;

   // rx_prev lets the idle receiver see a falling edge on the synchronized line
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_meta <= 1'b1;
         r_rx_sync <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_rx_meta <= rx_i;
         r_rx_sync <= r_rx_meta;
         r_rx_prev <= r_rx_sync;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
      end else begin
         r_rx_state <= w_rx_state_nx;
         r_rx_cnt   <= w_rx_cnt_nx;
         r_rx_bit   <= w_rx_bit_nx;
         r_rx_shift <= w_rx_shift_nx;
      end
   end

   assign w_cnt_full = (r_rx_cnt == c_CNT_W'(c_CLKS_PER_BIT - 1));

   always_comb begin
      w_rx_state_nx = r_rx_state;
      w_rx_cnt_nx   = r_rx_cnt + c_CNT_W'(1);
      w_rx_bit_nx   = r_rx_bit;
      w_rx_shift_nx = r_rx_shift;
      w_byte_valid  = 1'b0;
      w_frame_err   = 1'b0;
      case (r_rx_state)
         RX_IDLE: begin
            w_rx_cnt_nx = '0;
            if (r_rx_prev && !r_rx_sync) w_rx_state_nx = RX_START;
         end
         RX_START: begin
            if (r_rx_cnt == c_CNT_W'(c_HALF_BIT - 1)) begin
               w_rx_cnt_nx   = '0;
               w_rx_bit_nx   = '0;
               w_rx_state_nx = r_rx_sync ? RX_IDLE : RX_BITS;
            end
         end
         RX_BITS: begin
            if (w_cnt_full) begin
               w_rx_cnt_nx   = '0;
               w_rx_shift_nx = {r_rx_sync, r_rx_shift[7:1]};
               w_rx_bit_nx   = r_rx_bit + 3'd1;
               if (r_rx_bit == 3'd7) w_rx_state_nx = RX_STOP;
            end
         end
         RX_STOP: begin
            if (w_cnt_full) begin
               w_rx_state_nx = RX_IDLE;
               w_byte_valid  = r_rx_sync;
               w_frame_err   = !r_rx_sync;
            end
         end
         default: w_rx_state_nx = RX_IDLE;
      endcase
   end

   assign w_busy    = (r_state == LEN_LO) || (r_state == LEN_HI) ||
                      (r_state == DATA)   || (r_state == CSUM);
   assign w_timeout = w_busy && (r_tmo == c_TMO_W'(TIMEOUT_CLKS));
   assign w_n_rx    = {1'b0, r_rx_shift, r_len_lo};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= WAIT_SYNC;
         r_len_lo   <= '0;
         r_n        <= '0;
         r_idx      <= '0;
         r_word     <= '0;
         r_byte_cnt <= '0;
         r_csum     <= '0;
         r_tmo      <= '0;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else begin
         r_state    <= w_state_nx;
         r_len_lo   <= w_len_lo_nx;
         r_n        <= w_n_nx;
         r_idx      <= w_idx_nx;
         r_word     <= w_word_nx;
         r_byte_cnt <= w_byte_cnt_nx;
         r_csum     <= w_csum_nx;
         r_tmo      <= (w_byte_valid || !w_busy) ? '0 : r_tmo + c_TMO_W'(1);
         r_we       <= w_we_nx;
         r_addr     <= w_addr_nx;
         r_wdata    <= w_wdata_nx;
      end
   end

   always_comb begin
      w_state_nx    = r_state;
      w_len_lo_nx   = r_len_lo;
      w_n_nx        = r_n;
      w_idx_nx      = r_idx;
      w_word_nx     = r_word;
      w_byte_cnt_nx = r_byte_cnt;
      w_csum_nx     = r_csum;
      w_we_nx       = 1'b0;
      w_addr_nx     = r_addr;
      w_wdata_nx    = r_wdata;
      if (w_timeout || (w_busy && w_frame_err)) begin
         w_state_nx = ERROR;
      end else if (w_byte_valid) begin
         case (r_state)
            WAIT_SYNC, DONE, ERROR: begin
               if (r_rx_shift == c_SYNC) begin
                  w_state_nx = LEN_LO;
                  w_csum_nx  = '0;
               end
            end
            LEN_LO: begin
               w_len_lo_nx = r_rx_shift;
               w_state_nx  = LEN_HI;
            end
            LEN_HI: begin
               w_n_nx        = w_n_rx[ADDR_W:0];
               w_idx_nx      = '0;
               w_byte_cnt_nx = '0;
               if (w_n_rx > c_N_MAX)   w_state_nx = ERROR;
               else if (w_n_rx == '0)  w_state_nx = CSUM;
               else                    w_state_nx = DATA;
            end
            DATA: begin
               // little-endian words: first byte ends up in bits [7:0]
               w_csum_nx     = r_csum ^ r_rx_shift;
               w_word_nx     = {r_rx_shift, r_word[31:8]};
               w_byte_cnt_nx = r_byte_cnt + 2'd1;
               if (r_byte_cnt == 2'd3) begin
                  w_we_nx    = 1'b1;
                  w_addr_nx  = r_idx[ADDR_W-1:0];
                  w_wdata_nx = w_word_nx;
                  w_idx_nx   = r_idx + (ADDR_W + 1)'(1);
                  if (w_idx_nx == r_n) w_state_nx = CSUM;
               end
            end
            CSUM:    w_state_nx = (r_rx_shift == r_csum) ? DONE : ERROR;
            default: w_state_nx = WAIT_SYNC;
         endcase
      end
   end

   assign bus.im_we     = r_we;
   assign bus.im_addr   = r_addr;
   assign bus.im_wdata  = r_wdata;
   assign bus.core_hold = (r_state != DONE);
   assign bus.busy      = w_busy;
   assign bus.done      = (r_state == DONE);
   assign bus.err       = (r_state == ERROR);
endmodule
`default_nettype wire

// File: tb/tb_uart_imem_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_imem_loader
// Brief    : Self-checking bench: UART image stimulus against a protocol model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_imem_loader;
   localparam int c_CPB      = 10;
   localparam int c_TMO      = 500;
   localparam int c_OUT_DONE = 0;
   localparam int c_OUT_ERR  = 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rx  = 1'b1;
   int   checks = 0;
   int   errors = 0;

   logic [7:0]  img[$];
   logic [43:0] exp_q[$];

   always #5 clk = ~clk;

   uart_imem_loader_if #(.ADDR_W(12)) bus ();

   uart_imem_loader #(
      .CLK_FREQ(1000000), .BAUD(100000), .ADDR_W(12), .TIMEOUT_CLKS(c_TMO)
   ) dut (
      .clk(clk), .rst(rst), .rx_i(rx), .bus(bus)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   // Protocol-level reference: queues the writes the image must cause and
   // returns the final outcome (incomplete images end in a timeout error).
   function automatic int model_load();
      int         n;
      int         base;
      logic [7:0] x;
      n = int'(img[2]) * 256 + int'(img[1]);
      if (n > 4096) return c_OUT_ERR;
      x = 8'h00;
      for (int w = 0; w < n; w++) begin
         base = 3 + 4 * w;
         if (base + 3 >= img.size()) return c_OUT_ERR;
         exp_q.push_back({12'(w), img[base+3], img[base+2], img[base+1], img[base]});
         x = x ^ img[base] ^ img[base+1] ^ img[base+2] ^ img[base+3];
      end
      if (3 + 4 * n >= img.size()) return c_OUT_ERR;
      return (img[3+4*n] == x) ? c_OUT_DONE : c_OUT_ERR;
   endfunction

   task automatic send_byte(input logic [7:0] b, input bit good_stop);
      rx = 1'b0;
      repeat (c_CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (c_CPB) @(negedge clk);
      end
      rx = good_stop;
      repeat (c_CPB) @(negedge clk);
      rx = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic send_img();
      for (int i = 0; i < img.size(); i++) send_byte(img[i], 1'b1);
   endtask

   task automatic expect_end(input int bound, input int outc);
      int k;
      k = 0;
      while (bus.busy && k < bound) begin
         @(negedge clk);
         k++;
      end
      chk("settled_within_bound", {63'd0, bus.busy}, 64'd0);
      chk("done", {63'd0, bus.done}, {63'd0, outc == c_OUT_DONE});
      chk("err", {63'd0, bus.err}, {63'd0, outc == c_OUT_ERR});
      chk("core_hold", {63'd0, bus.core_hold}, {63'd0, outc != c_OUT_DONE});
      chk("writes_outstanding", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_core_hold"}, {63'd0, bus.core_hold}, 64'd1);
      chk({tag, "_im_we"},     {63'd0, bus.im_we}, 64'd0);
      chk({tag, "_im_addr"},   {52'd0, bus.im_addr}, 64'd0);
      chk({tag, "_im_wdata"},  {32'd0, bus.im_wdata}, 64'd0);
      chk({tag, "_busy_done_err"}, {61'd0, bus.busy, bus.done, bus.err}, 64'd0);
   endtask

   initial begin
      int         outc;
      logic [7:0] x;
      int         n;

      fork
         forever begin
            @(negedge clk);
            if (bus.im_we) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL im_we_unexpected: got addr %0h data %0h, required no write",
                           bus.im_addr, bus.im_wdata);
               end else if ({bus.im_addr, bus.im_wdata} !== exp_q[0]) begin
                  errors++;
                  $display("FAIL im_write: got %0h, required %0h",
                           {bus.im_addr, bus.im_wdata}, exp_q.pop_front());
               end else begin
                  void'(exp_q.pop_front());
               end
               chk("we_while_busy_and_held", {62'd0, bus.busy, bus.core_hold}, 64'd3);
            end
            chk("hold_iff_not_done", {63'd0, bus.core_hold}, {63'd0, ~bus.done});
         end
      join_none

      repeat (4) @(negedge clk);
      chk_reset_values("in_reset");
      rst = 1'b0;
      repeat (5) @(negedge clk);
      chk_reset_values("after_reset");

      // basic two-word image, with model pinned to hand-computed values
      img = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
              8'h6F, 8'h00, 8'h00, 8'h00, 8'h7C};
      outc = model_load();
      chk("model_outcome_good", 64'(outc), 64'(c_OUT_DONE));
      chk("model_nwrites", 64'(exp_q.size()), 64'd2);
      chk("model_w0", {20'd0, exp_q[0]}, {20'd0, 12'h000, 32'h00000013});
      chk("model_w1", {20'd0, exp_q[1]}, {20'd0, 12'h001, 32'h0000006F});
      send_img();
      expect_end(50, outc);

      img[11] = 8'h7D;
      outc = model_load();
      chk("model_outcome_badcsum", 64'(outc), 64'(c_OUT_ERR));
      send_img();
      expect_end(50, outc);

      img = '{8'hA5, 8'h00, 8'h00, 8'h00};
      outc = model_load();
      send_img();
      expect_end(50, outc);
      img[3] = 8'h01;
      outc = model_load();
      send_img();
      expect_end(50, outc);

      // truncated image: one complete word, then silence until timeout
      img = '{8'hA5, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      outc = model_load();
      chk("model_trunc_nwrites", 64'(exp_q.size()), 64'd1);
      send_img();
      expect_end(c_TMO + 200, outc);
      img = '{8'hA5, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
      outc = model_load();
      send_img();
      expect_end(50, outc);

      // N = 2^ADDR_W + 1 must fail straight after the length bytes
      img = '{8'hA5, 8'h01, 8'h10};
      outc = model_load();
      send_img();
      expect_end(20, outc);

      // bad stop bit in the middle of data
      img = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33};
      outc = model_load();
      send_img();
      send_byte(8'h44, 1'b0);
      expect_end(20, outc);

      // reset after the 6th data byte: exactly one write, then reset values
      img = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
      void'(model_load());
      send_img();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk_reset_values("mid_load_reset");
      repeat (200) @(negedge clk);
      chk("no_write_after_reset", 64'(exp_q.size()), 64'd0);
      chk_reset_values("idle_after_reset");
      img = '{8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
      outc = model_load();
      send_img();
      expect_end(50, outc);

      // randomized images, some with a leading junk byte and a bad checksum
      for (int it = 0; it < 8; it++) begin
         n = $urandom_range(1, 5);
         img = '{8'hA5, 8'(n), 8'h00};
         x = 8'h00;
         for (int i = 0; i < 4 * n; i++) begin
            img.push_back(8'($urandom));
            x = x ^ img[img.size()-1];
         end
         if ($urandom_range(0, 3) == 0) x = x ^ (8'h01 << $urandom_range(0, 7));
         img.push_back(x);
         outc = model_load();
         if ($urandom_range(0, 1) == 1) send_byte(8'h5A, 1'b1);
         send_img();
         expect_end(50, outc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- Hardware counterpart of the simulation memory preload: receives a program image over UART and writes it word-by-word into the instruction memory.
- Holds the core in reset while loading, then releases it so execution starts at PC 0.
- Sits between the board RX pin, the instruction memory write port and the core reset.

Parameters:
- CLK_FREQ, 27000000, system clock frequency in Hz
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_FREQ/BAUD (integer division)
- ADDR_W, 12, instruction memory word-address width; capacity 2^ADDR_W words
- TIMEOUT_CLKS, 2700000, max idle clocks between bytes once a load has started

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_i  in  1  UART RX line, asynchronous, idle high
- im_we  out  1  instruction memory write strobe, one-cycle pulse per word
- im_addr  out  ADDR_W  word address for im_we
- im_wdata  out  32  word data for im_we
- core_hold  out  1  core reset request; high = core held
- busy  out  1  load in progress (states LEN_LO..CSUM)
- done  out  1  last load completed with good checksum
- err  out  1  last load failed (framing, length, checksum or timeout)

Behaviour:
- All state and outputs are updated on the rising edge of clk. rst is synchronous and active-high.
- Reset values: core_hold=1; im_we=0, im_addr=0, im_wdata=0, busy=0, done=0, err=0. FSM=WAIT_SYNC.
- Reset during a load aborts it. No further writes occur. Words already written stay in memory.
- RX front end:
  - rx_i passes through a 2-FF synchronizer.
  - Idle until a falling edge is seen. Re-check the line at CLKS_PER_BIT/2; if it is high, discard as a glitch.
  - Sample 8 data bits, LSB first, at successive CLKS_PER_BIT intervals from that mid-start point.
  - Sample the stop bit the same way. Stop=0 is a framing error.
  - On a good frame, a byte-valid pulse lasts one cycle.
- Frame protocol: 0xA5, LEN_LO, LEN_HI, then 4*N data bytes (each word little-endian), then CSUM.
  - N = {LEN_HI, LEN_LO}.
  - CSUM = XOR of all data bytes only.
- FSM:
  - WAIT_SYNC: a byte of 0xA5 moves to LEN_LO and sets core_hold=1, done=0, err=0. Any other byte is ignored.
  - LEN_LO: store the byte and go to LEN_HI.
  - LEN_HI: form N.
    - N > 2^ADDR_W goes to ERROR.
    - N == 0 goes to CSUM.
    - Otherwise go to DATA with word index = 0.
  - DATA:
    - Shift bytes into the word assembler and XOR each into the checksum register.
    - On the 4th byte of a word, in the next cycle: im_we=1, im_addr=index, im_wdata=assembled word. Then increment index.
    - After word N-1 is written, go to CSUM.
  - CSUM: a byte equal to the checksum register goes to DONE, otherwise ERROR. With N==0 the expected value is 0x00.
  - DONE: core_hold=0, done=1. A byte of 0xA5 starts a new load (core_hold reasserts the next cycle).
  - ERROR: core_hold=1, err=1. A byte of 0xA5 starts a new load.
- Framing error in any state from LEN_LO through CSUM goes to ERROR. A framing error in WAIT_SYNC, DONE or ERROR is ignored.
- Timeout: a counter clears on every byte-valid. Reaching TIMEOUT_CLKS in LEN_LO, LEN_HI, DATA or CSUM goes to ERROR.
- im_we is never asserted outside DATA and never more than once per word. im_addr wraps only at N, which is at most 2^ADDR_W.
- core_hold is deasserted only in DONE. Every byte of a new image is written before the core is released.

Test Plan (CLK_FREQ=1000000, BAUD=100000, i.e. 10 clk/bit):
- Reset, then send A5 02 00 13 00 00 00 6F 00 00 00 7C -> im_we pulses twice: addr0=00000013, addr1=0000006F. Then done=1, core_hold falls, err=0.
- Same image but CSUM=7D -> both words written; err=1, core_hold stays 1, done=0.
- A5 00 00 00 -> no im_we; done=1, core_hold=0. Repeat with final byte 01 -> err=1.
- Send A5 03 00 and 5 data bytes, then idle TIMEOUT_CLKS -> err=1, exactly one im_we (addr0). Then send a full valid image -> done=1.
- A5 with N = 2^ADDR_W + 1 -> err=1 right after LEN_HI, no im_we. Separately, a stop bit forced low mid-DATA -> err=1.
- Assert rst after the 6th data byte of an N=2 image -> outputs return to reset values, no second write. A following 0xA5 starts a fresh load.
